cache_mem_ctrl: RTL
===================

// Module: cache_mem_ctrl
// PURPOSE
//  Memory-side controller directly downstream of the cache. On a cache miss it drains the victim line
//  (write-back) and refills the requested line. Both are word-serial transfers to main memory over a
//  req/ack bus. The refilled line is returned to the cache on ldata, qualified by write_back_finished.
// PARAMETERS
//  ADDR_W   32   address width (= `MAX_BIT_POS+1)
//  LINE_W   128  cache line width (= `CACHE_LINE_WIDTH)
//  WORD_W   32   memory bus word width; LINE_W/WORD_W = 4 beats per line
// PORTS
//  clk                  in   1       clock, all state on rising edge
//  rst_n                in   1       asynchronous active-low reset
//  write_back_enable    in   1       cache miss request, level; held until write_back_finished seen
//  write_back_dirty     in   1       victim line dirty; 0 = skip write-back phase
//  wb_addr              in   ADDR_W  victim line address (low 4 bits ignored)
//  fill_addr            in   ADDR_W  missed line address (low 4 bits ignored)
//  write_back_data      in   LINE_W  victim line contents
//  ldata                out  LINE_W  refilled line; valid while write_back_finished=1
//  write_back_finished  out  1       transaction done, level (4-phase handshake)
//  mem_req              out  1       memory beat request
//  mem_we               out  1       1 = write beat, 0 = read beat
//  mem_addr             out  ADDR_W  word address of current beat
//  mem_wdata            out  WORD_W  write data of current beat
//  mem_rdata            in   WORD_W  read data, valid with mem_ack on read beats
//  mem_ack              in   1       beat accepted/completed; counted only while mem_req=1
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; beat counter 0; all outputs 0, including ldata.
//    Reset mid-transaction aborts it silently. No partial memory write is retried.
//  - FSM: IDLE -> WB -> FILL -> DONE -> IDLE.
//    IDLE: when write_back_enable=1, latch both addrs (low 4 bits forced 0) and write_back_data,
//    clear the counter, then go to WB if write_back_dirty else to FILL.
//    WB:   mem_req=1, mem_we=1, mem_addr=wb_base+{cnt,2'b00}, mem_wdata=line[cnt*32 +: 32].
//    FILL: mem_req=1, mem_we=0, mem_addr=fill_base+{cnt,2'b00}; on ack, ldata[cnt*32 +: 32]<=mem_rdata.
//    On each mem_ack cycle cnt increments. On ack with cnt==3: cnt wraps to 0 and WB->FILL / FILL->DONE.
//    DONE: write_back_finished=1, mem_req=0; leave for IDLE only when write_back_enable=0.
//  - Word order is little-endian within the line: beat 0 = bits [31:0], beat 3 = bits [127:96].
//  - mem_req stays high across consecutive beats. Address and data update in the cycle after each ack.
//    mem_ack may be combinational (same cycle as req). Arbitrary wait states are allowed.
//  - Latency with zero-wait memory, counted from the edge that samples write_back_enable=1:
//    write_back_finished rises 5 cycles later when clean, 9 cycles later when dirty.
//  - ldata and write_back_finished are registered. ldata holds its value until the next FILL overwrites it.
//  - write_back_enable dropping before DONE: ignored; the transaction completes, then DONE exits at once.
//  - write_back_enable still high after IDLE re-entry: a new transaction starts only if the cache
//    re-raises it after seeing finished. The 4-phase rule makes this unambiguous.
//  - Inputs other than write_back_enable are sampled only in IDLE. Later changes have no effect.
//  - mem_ack while mem_req=0 is ignored. Address arithmetic wraps modulo 2^ADDR_W (no carry out).
// STRUCTURE
//  - config.sv supplies `MAX_BIT_POS and `CACHE_LINE_WIDTH. Add to it: `WORDS_PER_LINE (4) and
//    `LINE_OFFSET_BITS (4). Add the mem_ctrl_state_t enum {IDLE, WB, FILL, DONE} to the shared package.
//  - Single module, no sub-module. One FSM register, a 2-bit beat counter, and latched addr/line registers.
// TESTING
//  1 Clean miss: dirty=0, fill_addr=0x4000_0004, memory words 0x1111,0x2222,0x3333,0x4444, ack=1 ->
//    4 read beats at 0x4000_0000..0x4000_000C; ldata=128'h4444_..._3333_..._2222_..._1111 (per word);
//    finished high 5 cycles after request.
//  2 Dirty miss: wb_addr=0x0000_0000, data=128'h...0123_4567_0012_3456_0001_2345_0000_1234 ->
//    write beats 0x1234@0x0,0x12345@0x4,0x123456@0x8,0x1234567@0xC, then the fill; finished at cycle 9.
//  3 Wait states: ack every 3rd cycle -> addr/wdata held between acks; same ldata; no extra beats.
//  4 Handshake: hold write_back_enable 5 cycles after finished -> finished stays high, no new mem_req;
//    drop enable -> IDLE next cycle, finished=0.
//  5 Reset mid-WB after beat 1 -> all outputs 0 immediately; a new request restarts at beat 0.
//  6 Spurious mem_ack in IDLE and DONE -> counter and state unchanged; address 0xFFFF_FFF0 fill wraps correctly.

Source files
------------

// File: rtl/cache_mem_ctrl_pkg.sv
// ============================================================================
// Module      : cache_mem_ctrl_pkg
// Description : Shared widths and FSM state type for the cache memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_mem_ctrl_pkg;

   localparam int MAX_BIT_POS      = 31;
   localparam int CACHE_LINE_WIDTH = 128;
   localparam int WORDS_PER_LINE   = 4;
   localparam int LINE_OFFSET_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } mem_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_mem_ctrl.sv
// ============================================================================
// Module      : cache_mem_ctrl
// Description : Cache miss handler - word-serial victim write-back then line refill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_ctrl
   import cache_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = MAX_BIT_POS + 1,
   parameter int LINE_W = CACHE_LINE_WIDTH,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_back_enable,
   input  logic              write_back_dirty,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [LINE_W-1:0] write_back_data,
   output logic [LINE_W-1:0] ldata,
   output logic              write_back_finished,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

   mem_ctrl_state_t   state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] wb_base_q, wb_base_d;
   logic [ADDR_W-1:0] fill_base_q, fill_base_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [LINE_W-1:0] ldata_q, ldata_d;
   logic              fin_q, fin_d;
   logic [ADDR_W-1:0] beat_off;

   assign beat_off = {{(ADDR_W-4){1'b0}}, cnt_q, 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         wb_base_q   <= '0;
         fill_base_q <= '0;
         line_q      <= '0;
         ldata_q     <= '0;
         fin_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wb_base_q   <= wb_base_d;
         fill_base_q <= fill_base_d;
         line_q      <= line_d;
         ldata_q     <= ldata_d;
         fin_q       <= fin_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wb_base_d   = wb_base_q;
      fill_base_d = fill_base_q;
      line_d      = line_q;
      ldata_d     = ldata_q;
      fin_d       = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      case (state_q)
         IDLE: begin
            if (write_back_enable) begin
               wb_base_d   = wb_addr & LINE_MASK;
               fill_base_d = fill_addr & LINE_MASK;
               line_d      = write_back_data;
               cnt_d       = 2'd0;
               state_d     = write_back_dirty ? WB : FILL;
            end
         end
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wb_base_q + beat_off;
            mem_wdata = line_q[cnt_q*WORD_W +: WORD_W];
            if (mem_ack) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = fill_base_q + beat_off;
            if (mem_ack) begin
               ldata_d[cnt_q*WORD_W +: WORD_W] = mem_rdata;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = DONE;
            end
         end
         DONE: begin
            // Finished is shown for at least one cycle even if enable dropped early.
            fin_d = 1'b1;
            if (fin_q && !write_back_enable) begin
               fin_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ldata               = ldata_q;
   assign write_back_finished = fin_q;

endmodule

`default_nettype wire
